// File: rtl/restador_serie_nbits.sv
// restador_serie_nbits: bit-serial N-bit subtractor D = A - B - Bi, LSB first, with a start/busy/done handshake
module restador_serie_nbits #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bi,
  output logic [N-1:0] D,
  output logic         Bo,
  output logic         busy,
  output logic         done
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {REPOSO, RESTA, FIN} state_t;
  state_t state_q, state_d;
  logic [N-1:0] ra_q, ra_d, rb_q, rb_d, res_q, res_d, d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, bo_q, bo_d, done_q, done_d;
  logic a, b;
  assign a = ra_q[0];
  assign b = rb_q[0];
  assign D = d_q;
  assign Bo = bo_q;
  assign done = done_q;
  assign busy = state_q != REPOSO;
  // next-state: capture operands, one full-subtractor step per RESTA cycle, publish in FIN
  always_comb begin
    state_d = state_q;
    ra_d = ra_q;
    rb_d = rb_q;
    res_d = res_q;
    br_d = br_q;
    cnt_d = cnt_q;
    d_d = d_q;
    bo_d = bo_q;
    done_d = 1'b0;
    case (state_q)
      REPOSO: if (start) begin
        state_d = RESTA;
        ra_d = A;
        rb_d = B;
        br_d = Bi;
        cnt_d = '0;
      end
      RESTA: begin
        ra_d = ra_q >> 1;
        rb_d = rb_q >> 1;
        res_d = {a ^ b ^ br_q, res_q[N-1:1]};
        br_d = (~a & b) | (~(a ^ b) & br_q);
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(N - 1)) ? FIN : RESTA;
      end
      FIN: begin
        d_d = res_q;
        bo_d = br_q;
        done_d = 1'b1;
        state_d = REPOSO;
      end
      default: state_d = REPOSO;
    endcase
  end
  // state register; reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REPOSO;
      ra_q <= '0;
      rb_q <= '0;
      res_q <= '0;
      br_q <= 1'b0;
      cnt_q <= '0;
      d_q <= '0;
      bo_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
      res_q <= res_d;
      br_q <= br_d;
      cnt_q <= cnt_d;
      d_q <= d_d;
      bo_q <= bo_d;
      done_q <= done_d;
    end
  end
endmodule
